// File: rtl/mips_prog_loader.sv
// mips_prog_loader
//   Program loader for the single-cycle MIPS core. It takes one instruction per
//   beat as (kind, fields), builds the 32-bit MIPS word and writes it into
//   instruction memory at consecutive word addresses starting from 0.
//
//   Handshake: a beat transfers on a rising edge where in_valid & in_ready are
//   both 1. in_ready is high only in LOAD. in_valid may stay high while
//   in_ready is low, and no beat is taken in that case.
//
// Ports
//   clock, reset       rising-edge clock, synchronous active-high reset
//   start              open a new load session (in IDLE, DONE or ERR)
//   in_valid/in_ready  instruction beat handshake
//   in_kind            0..19 instruction kind; 20..31 are illegal
//   in_rs/rt/rd/sa     register and shift-amount fields
//   in_imm, in_target  immediate and jump target fields
//   in_last            marks the final instruction of the program
//   imem_we/addr/wdata IMEM write port, one strobe per word
//   count              number of words written in this session
//   busy/done/err      session status
//   state_dbg          current FSM state, for observation only
module mips_prog_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_sa,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        state_dbg
);

  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;
  logic              last_q, last_d;
  logic [ADDR_W:0]   count_inc;
  logic [31:0]       enc_word;
  logic              enc_legal;

  // Instruction encoder. It reverses the control-unit decode. Fields that the
  // kind does not use are forced to zero, and all other fields are copied as is.
  always_comb begin
    enc_word  = 32'h0000_0000;
    enc_legal = 1'b1;
    case (in_kind)
      5'd0:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h20};
      5'd1:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h22};
      5'd2:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h24};
      5'd3:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h25};
      5'd4:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h26};
      5'd5:  enc_word = {6'h00, 5'd0, in_rt, in_rd, in_sa, 6'h00};
      5'd6:  enc_word = {6'h00, 5'd0, in_rt, in_rd, in_sa, 6'h02};
      5'd7:  enc_word = {6'h00, 5'd0, in_rt, in_rd, in_sa, 6'h03};
      5'd8:  enc_word = {6'h00, in_rs, 15'd0, 6'h08};
      5'd9:  enc_word = {6'h08, in_rs, in_rt, in_imm};
      5'd10: enc_word = {6'h0C, in_rs, in_rt, in_imm};
      5'd11: enc_word = {6'h0D, in_rs, in_rt, in_imm};
      5'd12: enc_word = {6'h0E, in_rs, in_rt, in_imm};
      5'd13: enc_word = {6'h23, in_rs, in_rt, in_imm};
      5'd14: enc_word = {6'h2B, in_rs, in_rt, in_imm};
      5'd15: enc_word = {6'h04, in_rs, in_rt, in_imm};
      5'd16: enc_word = {6'h05, in_rs, in_rt, in_imm};
      5'd17: enc_word = {6'h0F, 5'd0, in_rt, in_imm};
      5'd18: enc_word = {6'h02, in_target};
      5'd19: enc_word = {6'h03, in_target};
      default: enc_legal = 1'b0;
    endcase
  end

  assign count_inc = count_q + (ADDR_W+1)'(1);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    addr_d   = addr_q;
    word_d   = word_q;
    last_d   = last_q;
    in_ready = 1'b0;
    imem_we  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LOAD;
          count_d = '0;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (enc_legal) begin
            word_d  = enc_word;
            addr_d  = count_q[ADDR_W-1:0];
            last_d  = in_last;
            state_d = S_WRITE;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_WRITE: begin
        imem_we = 1'b1;
        count_d = count_inc;
        // Once the last address has been written without a last beat,
        // no room is left and the session fails.
        if (last_q)                      state_d = S_DONE;
        else if (count_inc == DEPTH_CNT) state_d = S_ERR;
        else                             state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      last_q  <= last_d;
    end
  end

  assign imem_addr  = addr_q;
  assign imem_wdata = word_q;
  assign count      = count_q;
  assign busy       = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
module tb_mips_prog_loader;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int W      = ADDR_W + 32;

  localparam logic [5:0] FUNC_TAB [0:8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
                                            6'h00, 6'h02, 6'h03, 6'h08};
  localparam logic [5:0] OP_TAB [9:19]  = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23,
                                            6'h2B, 6'h04, 6'h05, 6'h0F, 6'h02, 6'h03};

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4:0]        in_kind = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_sa = '0;
  logic [15:0]       in_imm = '0;
  logic [25:0]       in_target = '0;
  logic              in_last = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              busy, done, err;
  logic [2:0]        state_dbg;

  int n_compared   = 0;
  int n_mismatched = 0;
  int exp_count    = 0;
  logic [W-1:0] exp_q[$];

  mips_prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_sa(in_sa),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference encoder: built from the opcode and funct tables.
  function automatic logic [31:0] model_encode(input int kind, input logic [4:0] rs, rt, rd, sa,
                                               input logic [15:0] imm, input logic [25:0] tgt);
    logic [31:0] w;
    if (kind <= 8) begin
      bit shift = (kind >= 5 && kind <= 7);
      bit jr    = (kind == 8);
      w = {6'h00, shift ? 5'd0 : rs, jr ? 5'd0 : rt, jr ? 5'd0 : rd,
           shift ? sa : 5'd0, FUNC_TAB[kind]};
    end else if (kind <= 17) begin
      w = {OP_TAB[kind], (kind == 17) ? 5'd0 : rs, rt, imm};
    end else begin
      w = {OP_TAB[kind], tgt};
    end
    return w;
  endfunction

  // monitor / scoreboard
  always @(negedge clock) begin
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write", imem_addr, imem_wdata);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("imem_write", 64'({imem_addr, imem_wdata}), 64'(e));
      end
    end
  end

  // driver tasks
  task automatic do_start();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    exp_count = 0;
    @(negedge clock);
    check("start_busy", 64'(busy), 64'd1);
    check("start_flags", 64'({done, err}), 64'd0);
    check("start_count", 64'(count), 64'd0);
    check("start_ready", 64'(in_ready), 64'd1);
  endtask

  // Sends one beat. If the beat is legal, the expected write is queued at the next address.
  task automatic send(input int kind, input logic [4:0] rs, rt, rd, sa,
                      input logic [15:0] imm, input logic [25:0] tgt, input logic last,
                      input logic legal, input logic [31:0] exp_word);
    int t;
    @(negedge clock);
    in_kind = 5'(kind); in_rs = rs; in_rt = rt; in_rd = rd; in_sa = sa;
    in_imm = imm; in_target = tgt; in_last = last; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 10) begin
      @(negedge clock);
      t++;
    end
    if (!in_ready) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end else if (legal) begin
      exp_q.push_back({ADDR_W'(exp_count), exp_word});
      exp_count++;
    end
    @(posedge clock);
    #1 in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_rand(input int kind, input logic last);
    logic [4:0] rs, rt, rd, sa;
    logic [15:0] imm;
    logic [25:0] tgt;
    rs = 5'($urandom_range(0, 31)); rt = 5'($urandom_range(0, 31));
    rd = 5'($urandom_range(0, 31)); sa = 5'($urandom_range(0, 31));
    imm = 16'($urandom); tgt = 26'($urandom);
    send(kind, rs, rt, rd, sa, imm, tgt, last, kind <= 19,
         model_encode(kind, rs, rt, rd, sa, imm, tgt));
  endtask

  task automatic wait_end(input string name, input logic exp_done, input logic exp_err);
    int t = 0;
    @(negedge clock);
    while (!(done || err) && t < 10) begin
      @(negedge clock);
      t++;
    end
    check({name, "_done"}, 64'(done), 64'(exp_done));
    check({name, "_err"}, 64'(err), 64'(exp_err));
    check({name, "_count"}, 64'(count), 64'(exp_count));
    check({name, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_outputs", 64'({imem_we, in_ready, busy, done, err}), 64'd0);
    check("reset_count", 64'(count), 64'd0);
    #1 reset = 1'b0;

    // single add
    do_start();
    send(0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 1'b1, 32'h00221820);
    wait_end("add", 1'b1, 1'b0);

    // three-instruction program
    do_start();
    send(9,  5'd1,  5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0, 1'b1, 32'h2022FFFF);
    send(5,  5'd7,  5'd5, 5'd4, 5'd2, 16'h0,    26'h0, 1'b0, 1'b1, 32'h00052080);
    send(13, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b1, 1'b1, 32'h8FA80004);
    wait_end("prog3", 1'b1, 1'b0);

    // jumps
    do_start();
    send(19, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000, 1'b0, 1'b1, 32'h0C100000);
    send(18, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000, 1'b1, 1'b1, 32'h08100000);
    wait_end("jumps", 1'b1, 1'b0);

    // illegal kind: error, no write, no accept until start
    do_start();
    send(25, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 1'b0, 1'b0, 32'h0);
    wait_end("illegal", 1'b0, 1'b1);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("err_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    do_start();

    // full memory with last on final beat
    for (int i = 0; i < DEPTH; i++) send_rand($urandom_range(0, 19), i == DEPTH - 1);
    wait_end("full_last", 1'b1, 1'b0);

    // full memory without last -> overflow
    do_start();
    for (int i = 0; i < DEPTH; i++) send_rand($urandom_range(0, 19), 1'b0);
    wait_end("overflow", 1'b0, 1'b1);

    // reset while in WRITE
    do_start();
    send_rand(3, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_write_we", 64'(imem_we), 64'd0);
    check("rst_write_status", 64'({busy, done, err}), 64'd0);
    check("rst_write_count", 64'(count), 64'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("idle_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;

    // random sessions
    for (int s = 0; s < 20; s++) begin
      int len;
      bit bad;
      len = $urandom_range(1, DEPTH);
      bad = 1'b0;
      do_start();
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 19) == 0) begin
          send_rand($urandom_range(20, 31), 1'b0);
          bad = 1'b1;
          break;
        end
        send_rand($urandom_range(0, 19), i == len - 1);
      end
      wait_end("random", !bad, bad);
    end

    repeat (4) @(negedge clock);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
